// File: rtl/hazard_controller.sv
// hazard_controller: pipeline sequencing for the 5-stage core.
// Covers the hazards forwarding cannot hide: load-use (one-cycle bubble),
// taken branches resolved in EX (IF/ID + ID/EX flush) and multi-cycle
// data-memory accesses (whole-pipeline freeze). Also keeps saturating
// counters of bubbles inserted and freeze cycles spent.
module hazard_controller #(
   parameter int MEM_LATENCY = 2,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [2:0]       id_src1,
   input  logic [2:0]       id_src2,
   input  logic             id_use1,
   input  logic             id_use2,
   input  logic [2:0]       ex_dst,
   input  logic             ex_wb,
   input  logic             ex_mem_read,
   input  logic             ex_branch_taken,
   input  logic             mem_req,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             id_ex_write,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             id_ex_bubble,
   output logic             busy,
   output logic [CNT_W-1:0] bubble_cnt,
   output logic [CNT_W-1:0] freeze_cnt
);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_DONE = 2'd2
   } state_t;

   // A single-cycle memory never needs a freeze.
   localparam bit FREEZE_EN = (MEM_LATENCY > 1);
   // Extra MEM_WAIT cycles beyond the first, loaded on the trigger cycle.
   localparam logic [3:0] WAIT_INIT = (MEM_LATENCY >= 3) ? 4'(MEM_LATENCY - 3) : 4'd0;

   state_t     state, state_nxt;
   logic [3:0] wait_cnt, wait_nxt;
   logic       load_use;
   logic       trigger;
   logic       freeze;
   logic       decode;
   logic       bubble_inc;
   logic       freeze_inc;

   // Dependence of the ID instruction on a load in EX; R0 is an ordinary register.
   assign load_use = ex_mem_read & ex_wb &
                     ((id_use1 & (id_src1 == ex_dst)) | (id_use2 & (id_src2 == ex_dst)));

   // Freeze starts only from RUN; in MEM_DONE the same access is still in MEM.
   assign trigger = FREEZE_EN & (state == RUN) & mem_req;
   assign freeze  = trigger | (state == MEM_WAIT);
   // Branch and load-use decode happens whenever the pipeline is not frozen.
   assign decode  = ((state == RUN) & ~trigger) | (state == MEM_DONE);

   // Next-state logic and all pipeline control outputs.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
      state_nxt    = state;
      wait_nxt     = wait_cnt;
      pc_write     = 1'b1;
      if_id_write  = 1'b1;
      id_ex_write  = 1'b1;
      ex_mem_write = 1'b1;
      mem_wb_write = 1'b1;
      if_id_flush  = 1'b0;
      id_ex_flush  = 1'b0;
      id_ex_bubble = 1'b0;
      busy         = 1'b0;
      bubble_inc   = 1'b0;
      freeze_inc   = 1'b0;

      if (rst) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
      end else begin
         busy = (state != RUN);

         if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            freeze_inc   = 1'b1;
         end else if (decode && ex_branch_taken) begin
            // The dependent ID instruction is squashed, so flush wins over load-use.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end else if (decode && load_use) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            bubble_inc   = 1'b1;
         end

         unique case (state)
            RUN: begin
               if (trigger) begin
                  if (MEM_LATENCY == 2) begin
                     state_nxt = MEM_DONE;
                  end else begin
                     state_nxt = MEM_WAIT;
                     wait_nxt  = WAIT_INIT;
                  end
               end
            end
            MEM_WAIT: begin
               if (wait_cnt == 4'd0) state_nxt = MEM_DONE;
               else                  wait_nxt  = wait_cnt - 4'd1;
            end
            MEM_DONE: state_nxt = RUN;
            default:  state_nxt = RUN;
         endcase
      end
   end

   // State register and wait counter; reset abandons any access in flight.
   always_ff @(posedge clk or posedge rst) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (rst) begin
         state    <= RUN;
         wait_cnt <= 4'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_nxt;
      end
   end

   // Saturating performance counters.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bubble_cnt <= '0;
         freeze_cnt <= '0;
      end else begin
         if (bubble_inc && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + 1'b1;
         if (freeze_inc && (freeze_cnt != '1)) freeze_cnt <= freeze_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_hazard_controller.sv
// Testbench for hazard_controller. Two instances share the stimulus:
// dut3 (MEM_LATENCY=3) is scoreboarded every cycle, dut1 (MEM_LATENCY=1)
// is checked for never freezing. Expected control words are pushed when a
// cycle's stimulus is driven and popped when the outputs are sampled.
module tb_hazard_controller;

   typedef struct packed {
      logic [2:0] src1;
      logic [2:0] src2;
      logic       use1;
      logic       use2;
      logic [2:0] dst;
      logic       wb;
      logic       mr;
      logic       br;
      logic       mreq;
   } stim_t;

   typedef struct packed {
      logic [8:0]  ctrl;
      logic [15:0] bcnt;
      logic [15:0] fcnt;
   } exp_t;

   // Control word: {pc, if_id, id_ex, ex_mem, mem_wb write, if_id_flush, id_ex_flush, bubble, busy}
   localparam logic [8:0] C_RST     = 9'b00000_00_0_0;
   localparam logic [8:0] C_RUN     = 9'b11111_00_0_0;
   localparam logic [8:0] C_LU      = 9'b00111_00_1_0;
   localparam logic [8:0] C_FL      = 9'b11111_11_0_0;
   localparam logic [8:0] C_FRZ     = 9'b00000_00_0_0;
   localparam logic [8:0] C_FRZB    = 9'b00000_00_0_1;
   localparam logic [8:0] C_DONE    = 9'b11111_00_0_1;
   localparam logic [8:0] C_DONE_LU = 9'b00111_00_1_1;
   localparam stim_t      IDLE      = '0;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  id_src1 = '0, id_src2 = '0, ex_dst = '0;
   logic        id_use1 = 1'b0, id_use2 = 1'b0, ex_wb = 1'b0, ex_mem_read = 1'b0;
   logic        ex_branch_taken = 1'b0, mem_req = 1'b0;

   logic        pc_write3, if_id_write3, id_ex_write3, ex_mem_write3, mem_wb_write3;
   logic        if_id_flush3, id_ex_flush3, id_ex_bubble3, busy3;
   logic [15:0] bubble_cnt3, freeze_cnt3;
   logic        pc_write1, if_id_write1, id_ex_write1, ex_mem_write1, mem_wb_write1;
   logic        if_id_flush1, id_ex_flush1, id_ex_bubble1, busy1;
   logic [15:0] bubble_cnt1, freeze_cnt1;
   logic [8:0]  obs3, obs1;

   int   n_checks = 0;
   int   n_fail   = 0;
   exp_t sb[$];
   logic [15:0] exp_b = '0;
   logic [15:0] exp_f = '0;

   always #5 clk = ~clk;

   hazard_controller #(.MEM_LATENCY(3), .CNT_W(16)) dut3 (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_dst(ex_dst), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .pc_write(pc_write3), .if_id_write(if_id_write3), .id_ex_write(id_ex_write3),
      .ex_mem_write(ex_mem_write3), .mem_wb_write(mem_wb_write3),
      .if_id_flush(if_id_flush3), .id_ex_flush(id_ex_flush3), .id_ex_bubble(id_ex_bubble3),
      .busy(busy3), .bubble_cnt(bubble_cnt3), .freeze_cnt(freeze_cnt3)
   );

   hazard_controller #(.MEM_LATENCY(1), .CNT_W(16)) dut1 (
      .clk(clk), .rst(rst),
      .id_src1(id_src1), .id_src2(id_src2), .id_use1(id_use1), .id_use2(id_use2),
      .ex_dst(ex_dst), .ex_wb(ex_wb), .ex_mem_read(ex_mem_read),
      .ex_branch_taken(ex_branch_taken), .mem_req(mem_req),
      .pc_write(pc_write1), .if_id_write(if_id_write1), .id_ex_write(id_ex_write1),
      .ex_mem_write(ex_mem_write1), .mem_wb_write(mem_wb_write1),
      .if_id_flush(if_id_flush1), .id_ex_flush(id_ex_flush1), .id_ex_bubble(id_ex_bubble1),
      .busy(busy1), .bubble_cnt(bubble_cnt1), .freeze_cnt(freeze_cnt1)
   );

   assign obs3 = {pc_write3, if_id_write3, id_ex_write3, ex_mem_write3, mem_wb_write3,
                  if_id_flush3, id_ex_flush3, id_ex_bubble3, busy3};
   assign obs1 = {pc_write1, if_id_write1, id_ex_write1, ex_mem_write1, mem_wb_write1,
                  if_id_flush1, id_ex_flush1, id_ex_bubble1, busy1};

   // Load-use pattern: load into d, ID reads d through src1.
   function automatic stim_t lu(input logic [2:0] d);
      stim_t s;
      s      = IDLE;
      s.dst  = d;
      s.src1 = d;
      s.use1 = 1'b1;
      s.wb   = 1'b1;
      s.mr   = 1'b1;
      return s;
   endfunction

   // Drive one cycle of stimulus, push its expectation, then wait for the sample point.
   task automatic apply(input stim_t s, input logic r, input logic [8:0] c,
                        input bit inc_b, input bit inc_f);
      exp_t e;
      @(posedge clk);
      #1;
      rst             = r;
      id_src1         = s.src1;
      id_src2         = s.src2;
      id_use1         = s.use1;
      id_use2         = s.use2;
      ex_dst          = s.dst;
      ex_wb           = s.wb;
      ex_mem_read     = s.mr;
      ex_branch_taken = s.br;
      mem_req         = s.mreq;
      e.ctrl = c;
      e.bcnt = exp_b;
      e.fcnt = exp_f;
      sb.push_back(e);
      if (inc_b && exp_b != 16'hFFFF) exp_b = exp_b + 16'd1;
      if (inc_f && exp_f != 16'hFFFF) exp_f = exp_f + 16'd1;
      @(negedge clk);
   endtask

   task automatic test_reset();
      exp_t e;
      apply(IDLE, 1'b1, C_RST, 0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
         n_fail++;
         $display("FAIL reset: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                  obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
      end
      apply(IDLE, 1'b0, C_RUN, 0, 0);
      e = sb.pop_front();
      n_checks++;
      if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
         n_fail++;
         $display("FAIL reset_release: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                  obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
      end
   endtask

   task automatic test_load_use();
      stim_t s[6]; logic [8:0] c[6]; bit ib[6];
      exp_t e;
      s[0] = lu(3'd5);                                            c[0] = C_LU;  ib[0] = 1;
      s[1] = lu(3'd5); s[1].use1 = 1'b0;                          c[1] = C_RUN; ib[1] = 0;
      s[2] = lu(3'd5); s[2].use1 = 1'b0; s[2].use2 = 1'b1; s[2].src2 = 3'd5;
                                                                  c[2] = C_LU;  ib[2] = 1;
      s[3] = lu(3'd5); s[3].wb = 1'b0;                            c[3] = C_RUN; ib[3] = 0;
      s[4] = lu(3'd5); s[4].src1 = 3'd4;                          c[4] = C_RUN; ib[4] = 0;
      s[5] = IDLE;                                                c[5] = C_RUN; ib[5] = 0;
      for (int i = 0; i < 6; i++) begin
         apply(s[i], 1'b0, c[i], ib[i], 0);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL load_use[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   task automatic test_flush_priority();
      stim_t s[3]; logic [8:0] c[3];
      exp_t e;
      s[0] = lu(3'd5); s[0].br = 1'b1; c[0] = C_FL;
      s[1] = IDLE;     s[1].br = 1'b1; c[1] = C_FL;
      s[2] = IDLE;                     c[2] = C_RUN;
      for (int i = 0; i < 3; i++) begin
         apply(s[i], 1'b0, c[i], 0, 0);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL flush_priority[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   task automatic test_addr_zero();
      stim_t s[2]; logic [8:0] c[2]; bit ib[2];
      exp_t e;
      s[0] = lu(3'd0); s[0].use1 = 1'b0; s[0].src1 = 3'd7; s[0].use2 = 1'b1; s[0].src2 = 3'd0;
      c[0] = C_LU;  ib[0] = 1;
      s[1] = IDLE;  c[1] = C_RUN; ib[1] = 0;
      for (int i = 0; i < 2; i++) begin
         apply(s[i], 1'b0, c[i], ib[i], 0);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL addr_zero[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   // MEM_LATENCY=3: trigger + one MEM_WAIT frozen, then MEM_DONE; busy 0,1,1,0.
   task automatic test_freeze();
      stim_t s[4]; logic [8:0] c[4]; bit inf[4];
      exp_t e;
      s[0] = IDLE; s[0].mreq = 1'b1; c[0] = C_FRZ;  inf[0] = 1;
      s[1] = s[0];                   c[1] = C_FRZB; inf[1] = 1;
      s[2] = s[0];                   c[2] = C_DONE; inf[2] = 0;
      s[3] = IDLE;                   c[3] = C_RUN;  inf[3] = 0;
      for (int i = 0; i < 4; i++) begin
         apply(s[i], 1'b0, c[i], 0, inf[i]);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL freeze[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   // Load-use held through a freeze surfaces only on the MEM_DONE cycle.
   task automatic test_deferred();
      stim_t s[4]; logic [8:0] c[4]; bit ib[4], inf[4];
      exp_t e;
      s[0] = lu(3'd3); s[0].mreq = 1'b1; c[0] = C_FRZ;     ib[0] = 0; inf[0] = 1;
      s[1] = s[0];                       c[1] = C_FRZB;    ib[1] = 0; inf[1] = 1;
      s[2] = s[0];                       c[2] = C_DONE_LU; ib[2] = 1; inf[2] = 0;
      s[3] = IDLE;                       c[3] = C_RUN;     ib[3] = 0; inf[3] = 0;
      for (int i = 0; i < 4; i++) begin
         apply(s[i], 1'b0, c[i], ib[i], inf[i]);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL deferred[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   task automatic test_back_to_back();
      stim_t s[7]; logic [8:0] c[7]; bit inf[7];
      exp_t e;
      for (int i = 0; i < 6; i++) begin
         s[i] = IDLE;
         s[i].mreq = 1'b1;
      end
      c[0] = C_FRZ;  inf[0] = 1;
      c[1] = C_FRZB; inf[1] = 1;
      c[2] = C_DONE; inf[2] = 0;
      c[3] = C_FRZ;  inf[3] = 1;
      c[4] = C_FRZB; inf[4] = 1;
      c[5] = C_DONE; inf[5] = 0;
      s[6] = IDLE;   c[6] = C_RUN; inf[6] = 0;
      for (int i = 0; i < 7; i++) begin
         apply(s[i], 1'b0, c[i], 0, inf[i]);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL back_to_back[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   // MEM_LATENCY=1 never freezes while dut3 goes through its normal access.
   task automatic test_lat1();
      stim_t s[3]; logic [8:0] c[3]; bit inf[3];
      exp_t e;
      s[0] = IDLE; s[0].mreq = 1'b1; c[0] = C_FRZ;  inf[0] = 1;
      s[1] = s[0];                   c[1] = C_FRZB; inf[1] = 1;
      s[2] = s[0];                   c[2] = C_DONE; inf[2] = 0;
      for (int i = 0; i < 3; i++) begin
         apply(s[i], 1'b0, c[i], 0, inf[i]);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL lat3_ref[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
         n_checks++;
         if ({obs1, freeze_cnt1} !== {C_RUN, 16'd0}) begin
            n_fail++;
            $display("FAIL lat1[%0d]: got ctrl=%b f=%0d, want ctrl=%b f=0",
                     i, obs1, freeze_cnt1, C_RUN);
         end
      end
   endtask

   // Reset while in MEM_WAIT: enables drop at once, then clean RUN after release.
   task automatic test_reset_mid_freeze();
      stim_t s[5]; logic [8:0] c[5]; logic r[5]; bit ib[5], inf[5];
      exp_t e;
      s[0] = IDLE; s[0].mreq = 1'b1; r[0] = 0; c[0] = C_FRZ; ib[0] = 0; inf[0] = 1;
      s[1] = s[0];                   r[1] = 1; c[1] = C_RST; ib[1] = 0; inf[1] = 0;
      s[2] = IDLE;                   r[2] = 0; c[2] = C_RUN; ib[2] = 0; inf[2] = 0;
      s[3] = lu(3'd6);               r[3] = 0; c[3] = C_LU;  ib[3] = 1; inf[3] = 0;
      s[4] = IDLE;                   r[4] = 0; c[4] = C_RUN; ib[4] = 0; inf[4] = 0;
      for (int i = 0; i < 5; i++) begin
         if (r[i]) begin
            exp_b = '0;
            exp_f = '0;
         end
         apply(s[i], r[i], c[i], ib[i], inf[i]);
         e = sb.pop_front();
         n_checks++;
         if ({obs3, bubble_cnt3, freeze_cnt3} !== {e.ctrl, e.bcnt, e.fcnt}) begin
            n_fail++;
            $display("FAIL reset_mid_freeze[%0d]: got ctrl=%b b=%0d f=%0d, want ctrl=%b b=%0d f=%0d",
                     i, obs3, bubble_cnt3, freeze_cnt3, e.ctrl, e.bcnt, e.fcnt);
         end
      end
   endtask

   // Drive load-use until bubble_cnt must have reached all-ones, then keep going.
   task automatic test_saturation();
      int n;
      n = 65535 - int'(exp_b) + 4;
      @(posedge clk);
      #1;
      id_src1 = 3'd2; id_use1 = 1'b1; id_use2 = 1'b0; ex_dst = 3'd2;
      ex_wb = 1'b1; ex_mem_read = 1'b1; ex_branch_taken = 1'b0; mem_req = 1'b0;
      for (int i = 0; i < n; i++) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({obs3, bubble_cnt3} !== {C_LU, 16'hFFFF}) begin
         n_fail++;
         $display("FAIL saturation: got ctrl=%b b=%h, want ctrl=%b b=ffff", obs3, bubble_cnt3, C_LU);
      end
      @(negedge clk);
      n_checks++;
      if (bubble_cnt3 !== 16'hFFFF) begin
         n_fail++;
         $display("FAIL saturation_hold: got b=%h, want b=ffff", bubble_cnt3);
      end
      exp_b = 16'hFFFF;
   endtask

   initial begin
      test_reset();
      test_load_use();
      test_flush_priority();
      test_addr_zero();
      test_freeze();
      test_deferred();
      test_back_to_back();
      test_lat1();
      test_reset_mid_freeze();
      test_saturation();
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
